bank_demux_buf: RTL and testbench

- Parametrised, buffered successor to the 2-way demux. Routes a data word to one of N_OUT output channels by select, or to all channels in broadcast mode.
- Uses a valid/ready handshake on every port and a 2-entry buffer, so no combinational path runs from inputs to outputs.
- Sits between the RAM address/request front end and the per-bank interfaces of the 64KB RAM.
- Flags and counts requests whose select is out of range.

---
 rtl/bank_demux_buf.sv | 154 +++++++++++++++
 tb/tb_bank_demux_buf.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_demux_buf.sv
// Buffered 1-to-N_OUT demux with broadcast. Two-entry FIFO in front of the per-bank channels.
// Every output is derived from registered state only, so nothing combinational runs from input to output.
module bank_demux_buf #(
    parameter int N_OUT  = 8,
    parameter int SEL_W  = 3,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_bcast,
    input  logic [DATA_W-1:0] in_data,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              err_sel,
    output logic [7:0]        drop_cnt
);

    localparam logic [SEL_W:0]   LP_NOUT  = (SEL_W+1)'(N_OUT);
    localparam logic [1:0]       LP_DEPTH = 2'(DEPTH);
    localparam logic [N_OUT-1:0] LP_ALL   = '1;
    localparam logic [N_OUT-1:0] LP_ONE   = N_OUT'(1);

    logic [1:0]        r_count;
    logic              r_head;
    logic              r_tail;
    logic              r_live;
    logic              r_bcast [DEPTH];
    logic [SEL_W-1:0]  r_sel   [DEPTH];
    logic [DATA_W-1:0] r_data  [DEPTH];
    logic [N_OUT-1:0]  r_acc_mask;
    logic [DATA_W-1:0] r_last_data;
    logic              r_err;
    logic [7:0]        r_drop_cnt;

    logic              w_has_head;
    logic              w_head_bcast;
    logic [SEL_W-1:0]  w_head_sel;
    logic [DATA_W-1:0] w_head_data;
    logic [N_OUT-1:0]  w_out_valid;
    logic [N_OUT-1:0]  w_xfer;
    logic              w_pop;
    logic              w_accept;
    logic              w_sel_bad;
    logic              w_drop;
    logic              w_push;
    logic [1:0]        w_count_nxt;
    logic [N_OUT-1:0]  w_acc_nxt;

    // r_live keeps in_ready low until the first edge after reset release.
    assign in_ready  = r_live & (r_count < LP_DEPTH);
    assign out_valid = w_out_valid;
    assign out_data  = w_has_head ? w_head_data : r_last_data;
    assign err_sel   = r_err;
    assign drop_cnt  = r_drop_cnt;

    always_comb begin
        w_has_head   = (r_count != 2'd0);
        w_head_bcast = r_bcast[r_head];
        w_head_sel   = r_sel[r_head];
        w_head_data  = r_data[r_head];
        w_out_valid  = '0;
        if (w_has_head) begin
            if (w_head_bcast) begin
                w_out_valid = LP_ALL & ~r_acc_mask;
            end else begin
                w_out_valid = LP_ONE << w_head_sel;
            end
        end
        w_xfer = w_out_valid & out_ready;
        w_pop  = 1'b0;
        if (w_has_head) begin
            w_pop = w_head_bcast ? ((r_acc_mask | w_xfer) == LP_ALL) : (w_xfer != '0);
        end
    end

    // A broadcast head remembers which channels already took it so none sees it twice.
    always_comb begin
        w_acc_nxt = r_acc_mask;
        if (w_pop) begin
            w_acc_nxt = '0;
        end else if (w_has_head && w_head_bcast) begin
            w_acc_nxt = r_acc_mask | w_xfer;
        end
    end

    always_comb begin
        w_accept  = in_valid & in_ready;
        w_sel_bad = ~in_bcast & ({1'b0, in_sel} >= LP_NOUT);
        w_drop    = w_accept & w_sel_bad;
        w_push    = w_accept & ~w_sel_bad;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_live  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_bcast[i] <= 1'b0;
                r_sel[i]   <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            r_live  <= 1'b1;
            r_count <= w_count_nxt;
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (w_push) begin
                r_bcast[r_tail] <= in_bcast;
                r_sel[r_tail]   <= in_sel;
                r_data[r_tail]  <= in_data;
                r_tail          <= ~r_tail;
            end
        end
    end

    // out_data keeps showing the last presented word once the buffer drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_mask  <= '0;
            r_last_data <= '0;
        end else begin
            r_acc_mask <= w_acc_nxt;
            if (w_has_head) begin
                r_last_data <= w_head_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_err <= w_drop;
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bank_demux_buf.sv
// Bench for bank_demux_buf: an 8-channel instance checked against a queue model, plus a
// 6-channel instance for out-of-range select handling.
module tb_bank_demux_buf;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       aInValid = 1'b0;
    logic       aInBcast = 1'b0;
    logic [2:0] aInSel   = '0;
    logic [7:0] aInData  = '0;
    logic [7:0] aOutReady = '0;
    logic       aInReady;
    logic [7:0] aOutValid;
    logic [7:0] aOutData;
    logic       aErrSel;
    logic [7:0] aDropCnt;

    logic       bInValid = 1'b0;
    logic       bInBcast = 1'b0;
    logic [2:0] bInSel   = '0;
    logic [7:0] bInData  = '0;
    logic [5:0] bOutReady = '0;
    logic       bInReady;
    logic [5:0] bOutValid;
    logic [7:0] bOutData;
    logic       bErrSel;
    logic [7:0] bDropCnt;

    bank_demux_buf #(.N_OUT(8), .SEL_W(3), .DATA_W(8), .DEPTH(2)) dutA (
        .clk(clk), .rst_n(rst_n), .in_valid(aInValid), .in_ready(aInReady), .in_sel(aInSel),
        .in_bcast(aInBcast), .in_data(aInData), .out_valid(aOutValid), .out_ready(aOutReady),
        .out_data(aOutData), .err_sel(aErrSel), .drop_cnt(aDropCnt)
    );

    bank_demux_buf #(.N_OUT(6), .SEL_W(3), .DATA_W(8), .DEPTH(2)) dutB (
        .clk(clk), .rst_n(rst_n), .in_valid(bInValid), .in_ready(bInReady), .in_sel(bInSel),
        .in_bcast(bInBcast), .in_data(bInData), .out_valid(bOutValid), .out_ready(bOutReady),
        .out_data(bOutData), .err_sel(bErrSel), .drop_cnt(bDropCnt)
    );

    int passed = 0;
    int total  = 0;

    // Reference model of dutA: pending requests in arrival order, plus the set of
    // channels that have already taken the broadcast at the front.
    typedef struct { logic bc; logic [2:0] sel; logic [7:0] data; } entry_t;
    entry_t     mq[$];
    logic [7:0] mDone = '0;
    logic [7:0] mLast = '0;
    bit         mLive = 1'b0;

    function automatic logic [7:0] mValid();
        if (mq.size() == 0) return 8'h00;
        if (mq[0].bc) return ~mDone;
        return 8'h01 << mq[0].sel;
    endfunction

    function automatic logic mReady();
        return mLive && (mq.size() < 2);
    endfunction

    function automatic logic [7:0] mData();
        return (mq.size() > 0) ? mq[0].data : mLast;
    endfunction

    task automatic modelReset();
        mq.delete();
        mDone = '0;
        mLast = '0;
        mLive = 1'b0;
    endtask

    task automatic modelEdge();
        logic [7:0] xfer;
        bit         pop;
        bit         acc;
        entry_t     e;
        if (!rst_n) begin
            modelReset();
            return;
        end
        xfer = mValid() & aOutReady;
        pop  = 1'b0;
        if (mq.size() > 0) pop = mq[0].bc ? ((mDone | xfer) == 8'hFF) : (xfer != 8'h00);
        acc   = aInValid && mReady();
        mLast = mData();
        if (pop) begin
            void'(mq.pop_front());
            mDone = '0;
        end else if (mq.size() > 0) begin
            mDone = mDone | xfer;
        end
        if (acc) begin
            e.bc = aInBcast; e.sel = aInSel; e.data = aInData;
            mq.push_back(e);
        end
        mLive = 1'b1;
    endtask

    // Inputs are set at a falling edge; this advances the model across the next rising edge.
    task automatic cycle();
        modelEdge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        #1 rst_n = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        total++; if (aInReady !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", aInReady); else passed++;
        total++; if (aOutValid !== 8'h00) $display("FAIL rst_out_valid got=%h exp=00", aOutValid); else passed++;
        total++; if (aOutData !== 8'h00) $display("FAIL rst_out_data got=%h exp=00", aOutData); else passed++;
        total++; if (aErrSel !== 1'b0) $display("FAIL rst_err_sel got=%b exp=0", aErrSel); else passed++;
        total++; if (bDropCnt !== 8'h00) $display("FAIL rst_drop_cnt got=%h exp=00", bDropCnt); else passed++;
        rst_n = 1'b1;
        cycle();
        total++; if (aInReady !== 1'b1) $display("FAIL rel_in_ready got=%b exp=1", aInReady); else passed++;
        total++; if (bInReady !== 1'b1) $display("FAIL rel_in_ready_b got=%b exp=1", bInReady); else passed++;
        aOutReady = 8'h00;
        aInValid = 1'b1; aInSel = 3'd4; aInData = 8'h44;
        cycle();
        aInSel = 3'd6; aInData = 8'h66;
        cycle();
        aInValid = 1'b0;
        total++; if (aInReady !== 1'b0) $display("FAIL full_in_ready got=%b exp=0", aInReady); else passed++;
        total++; if (aOutValid !== 8'h10) $display("FAIL full_out_valid got=%h exp=10", aOutValid); else passed++;
        rst_n = 1'b0;
        modelReset();
        #1;
        total++; if (aOutValid !== 8'h00) $display("FAIL async_out_valid got=%h exp=00", aOutValid); else passed++;
        total++; if (aInReady !== 1'b0) $display("FAIL async_in_ready got=%b exp=0", aInReady); else passed++;
        @(negedge clk);
        repeat (2) cycle();
        total++; if (aDropCnt !== 8'h00) $display("FAIL midrst_drop_cnt got=%h exp=00", aDropCnt); else passed++;
        rst_n = 1'b1;
        cycle();
        total++; if (aInReady !== 1'b1) $display("FAIL midrel_in_ready got=%b exp=1", aInReady); else passed++;
        total++; if (aOutData !== 8'h00) $display("FAIL midrel_out_data got=%h exp=00", aOutData); else passed++;
        aOutReady = 8'hFF;
        repeat (3) begin
            cycle();
            total++; if (aOutValid !== 8'h00) $display("FAIL no_replay got=%h exp=00", aOutValid); else passed++;
        end
    endtask

    task automatic test_single_route();
        $display("[TB] test_single_route");
        aOutReady = 8'hFF;
        aInValid = 1'b1; aInBcast = 1'b0; aInSel = 3'd5; aInData = 8'hA5;
        cycle();
        aInValid = 1'b0;
        total++; if (aOutValid !== 8'h20) $display("FAIL route_valid got=%h exp=20", aOutValid); else passed++;
        total++; if (aOutData !== 8'hA5) $display("FAIL route_data got=%h exp=a5", aOutData); else passed++;
        cycle();
        total++; if (aOutValid !== 8'h00) $display("FAIL route_popped got=%h exp=00", aOutValid); else passed++;
        total++; if (aOutData !== 8'hA5) $display("FAIL route_hold_data got=%h exp=a5", aOutData); else passed++;
    endtask

    task automatic test_backpressure();
        $display("[TB] test_backpressure");
        aOutReady = 8'h00;
        aInValid = 1'b1; aInSel = 3'd1; aInData = 8'h11;
        cycle();
        aInSel = 3'd2; aInData = 8'h22;
        cycle();
        total++; if (aInReady !== 1'b0) $display("FAIL bp_full got=%b exp=0", aInReady); else passed++;
        total++; if (aOutValid !== 8'h02) $display("FAIL bp_head_valid got=%h exp=02", aOutValid); else passed++;
        total++; if (aOutData !== 8'h11) $display("FAIL bp_head_data got=%h exp=11", aOutData); else passed++;
        aInSel = 3'd3; aInData = 8'h33;
        cycle();
        total++; if (aInReady !== 1'b0) $display("FAIL bp_held got=%b exp=0", aInReady); else passed++;
        total++; if (aOutValid !== 8'h02) $display("FAIL bp_stable got=%h exp=02", aOutValid); else passed++;
        aOutReady = 8'h02;
        cycle();
        total++; if (aOutValid !== 8'h04) $display("FAIL bp_second_valid got=%h exp=04", aOutValid); else passed++;
        total++; if (aOutData !== 8'h22) $display("FAIL bp_second_data got=%h exp=22", aOutData); else passed++;
        total++; if (aInReady !== 1'b1) $display("FAIL bp_slot_freed got=%b exp=1", aInReady); else passed++;
        cycle();
        aInValid = 1'b0;
        total++; if (aInReady !== 1'b0) $display("FAIL bp_third_taken got=%b exp=0", aInReady); else passed++;
        aOutReady = 8'hFF;
        cycle();
        total++; if (aOutValid !== 8'h08) $display("FAIL bp_third_valid got=%h exp=08", aOutValid); else passed++;
        total++; if (aOutData !== 8'h33) $display("FAIL bp_third_data got=%h exp=33", aOutData); else passed++;
        cycle();
        total++; if (aOutValid !== 8'h00) $display("FAIL bp_drained got=%h exp=00", aOutValid); else passed++;
    endtask

    task automatic test_broadcast();
        int got[8];
        $display("[TB] test_broadcast");
        for (int k = 0; k < 8; k++) got[k] = 0;
        aOutReady = 8'h00;
        aInValid = 1'b1; aInBcast = 1'b1; aInSel = 3'd5; aInData = 8'h3C;
        cycle();
        aInValid = 1'b0; aInBcast = 1'b0;
        total++; if (aOutValid !== 8'hFF) $display("FAIL bc_all got=%h exp=ff", aOutValid); else passed++;
        total++; if (aOutData !== 8'h3C) $display("FAIL bc_data got=%h exp=3c", aOutData); else passed++;
        aOutReady = 8'h0F;
        for (int k = 0; k < 8; k++) if (aOutValid[k] && aOutReady[k]) got[k]++;
        cycle();
        total++; if (aOutValid !== 8'hF0) $display("FAIL bc_partial got=%h exp=f0", aOutValid); else passed++;
        total++; if (aOutData !== 8'h3C) $display("FAIL bc_partial_data got=%h exp=3c", aOutData); else passed++;
        aOutReady = 8'hF0;
        for (int k = 0; k < 8; k++) if (aOutValid[k] && aOutReady[k]) got[k]++;
        cycle();
        total++; if (aOutValid !== 8'h00) $display("FAIL bc_popped got=%h exp=00", aOutValid); else passed++;
        for (int k = 0; k < 8; k++) begin
            total++; if (got[k] !== 1) $display("FAIL bc_once ch=%0d got=%0d exp=1", k, got[k]); else passed++;
        end
    endtask

    task automatic test_invalid_sel();
        $display("[TB] test_invalid_sel");
        bOutReady = 6'h3F;
        bInValid = 1'b1; bInBcast = 1'b0; bInSel = 3'd7; bInData = 8'h77;
        cycle();
        bInValid = 1'b0;
        total++; if (bErrSel !== 1'b1) $display("FAIL inv_err got=%b exp=1", bErrSel); else passed++;
        total++; if (bDropCnt !== 8'd1) $display("FAIL inv_cnt got=%0d exp=1", bDropCnt); else passed++;
        total++; if (bOutValid !== 6'h00) $display("FAIL inv_not_stored got=%h exp=00", bOutValid); else passed++;
        cycle();
        total++; if (bErrSel !== 1'b0) $display("FAIL inv_err_pulse got=%b exp=0", bErrSel); else passed++;
        bInValid = 1'b1; bInSel = 3'd5; bInData = 8'hC5;
        cycle();
        bInValid = 1'b0;
        total++; if (bOutValid !== 6'h20) $display("FAIL inv_top_ch got=%h exp=20", bOutValid); else passed++;
        total++; if (bErrSel !== 1'b0) $display("FAIL inv_top_no_err got=%b exp=0", bErrSel); else passed++;
        cycle();
        bInValid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bInSel = 3'(6 + $urandom_range(0, 1));
            bInData = 8'($urandom);
            cycle();
        end
        bInValid = 1'b0;
        total++; if (bDropCnt !== 8'd255) $display("FAIL inv_saturate got=%0d exp=255", bDropCnt); else passed++;
        total++; if (bInReady !== 1'b1) $display("FAIL inv_ready got=%b exp=1", bInReady); else passed++;
        bOutReady = 6'h00;
        bInValid = 1'b1; bInSel = 3'd3; bInData = 8'h5A;
        cycle();
        total++; if (bOutValid !== 6'h08) $display("FAIL inv_pre_pop got=%h exp=08", bOutValid); else passed++;
        bOutReady = 6'h3F; bInSel = 3'd7;
        cycle();
        bInValid = 1'b0;
        total++; if (bOutValid !== 6'h00) $display("FAIL drop_with_pop got=%h exp=00", bOutValid); else passed++;
        total++; if (bErrSel !== 1'b1) $display("FAIL drop_with_pop_err got=%b exp=1", bErrSel); else passed++;
        total++; if (bOutData !== 8'h5A) $display("FAIL drop_with_pop_data got=%h exp=5a", bOutData); else passed++;
        total++; if (bDropCnt !== 8'd255) $display("FAIL inv_hold got=%0d exp=255", bDropCnt); else passed++;
    endtask

    task automatic test_streaming();
        logic [7:0] expValid;
        logic [7:0] expData;
        $display("[TB] test_streaming");
        aOutReady = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            aInValid = 1'b1; aInBcast = 1'b0; aInSel = 3'(i % 8); aInData = 8'($urandom);
            expValid = 8'h01 << (i % 8);
            expData = aInData;
            cycle();
            total++; if (aInReady !== 1'b1) $display("FAIL stream_ready i=%0d got=%b exp=1", i, aInReady); else passed++;
            total++; if (aOutValid !== expValid) $display("FAIL stream_valid i=%0d got=%h exp=%h", i, aOutValid, expValid); else passed++;
            total++; if (aOutData !== expData) $display("FAIL stream_data i=%0d got=%h exp=%h", i, aOutData, expData); else passed++;
        end
        aInValid = 1'b0;
        cycle();
        total++; if (aOutValid !== 8'h00) $display("FAIL stream_end got=%h exp=00", aOutValid); else passed++;
    endtask

    task automatic test_random();
        $display("[TB] test_random");
        for (int n = 0; n < 500; n++) begin
            aInValid  = 1'($urandom_range(0, 1));
            aInBcast  = ($urandom_range(0, 3) == 0);
            aInSel    = 3'($urandom);
            aInData   = 8'($urandom);
            aOutReady = 8'($urandom) | 8'($urandom);
            cycle();
            total++; if (aInReady !== mReady()) $display("FAIL rand_ready n=%0d got=%b exp=%b", n, aInReady, mReady()); else passed++;
            total++; if (aOutValid !== mValid()) $display("FAIL rand_valid n=%0d got=%h exp=%h", n, aOutValid, mValid()); else passed++;
            total++; if (aOutData !== mData()) $display("FAIL rand_data n=%0d got=%h exp=%h", n, aOutData, mData()); else passed++;
        end
        aInValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_single_route();
        test_backpressure();
        test_broadcast();
        test_invalid_sel();
        test_streaming();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
